// File: rtl/envelope_detector.sv
// Windowed envelope detector: rectifies a signed sample stream and reports the
// mean and peak magnitude of every block of 2**WINDOW_LOG2 valid samples.
module envelope_detector #(
    parameter int DATA_DW     = 17,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_DW-1:0] data_i,
    input  logic               valid_i,
    input  logic               clear_i,
    output logic [DATA_DW-1:0] mean_o,
    output logic [DATA_DW-1:0] peak_o,
    output logic               valid_o,
    output logic               busy_o
);

    localparam int ACC_DW = DATA_DW + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] LAST_CNT = {WINDOW_LOG2{1'b1}};

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

    logic [DATA_DW-1:0]     magQ, magD;
    logic                   magVldQ, magVldD;

    state_t                 stateQ, stateD;
    logic [ACC_DW-1:0]      accQ, accD;
    logic [DATA_DW-1:0]     peakQ, peakD;
    logic [WINDOW_LOG2-1:0] cntQ, cntD;

    logic [DATA_DW-1:0]     meanOutQ, meanOutD;
    logic [DATA_DW-1:0]     peakOutQ, peakOutD;
    logic                   validOutQ, validOutD;

    logic [ACC_DW-1:0]      accSum;
    logic [DATA_DW-1:0]     magMax;

    // Unsigned negation is exact for the most-negative input: it maps onto
    // the MSB alone, which still fits in DATA_DW unsigned bits.
    always_comb begin
        magD    = magQ;
        magVldD = 1'b0;
        if (!clear_i && valid_i) begin
            magD    = data_i[DATA_DW-1] ? (~data_i + DATA_DW'(1)) : data_i;
            magVldD = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            magQ    <= '0;
            magVldQ <= 1'b0;
        end else begin
            magQ    <= magD;
            magVldQ <= magVldD;
        end
    end

    assign accSum = accQ + ACC_DW'(magQ);
    assign magMax = (magQ > peakQ) ? magQ : peakQ;

    // Window accumulation; clear_i wins over any magnitude arriving this cycle.
    always_comb begin
        stateD    = stateQ;
        accD      = accQ;
        peakD     = peakQ;
        cntD      = cntQ;
        meanOutD  = meanOutQ;
        peakOutD  = peakOutQ;
        validOutD = 1'b0;

        if (clear_i) begin
            stateD = IDLE;
            accD   = '0;
            peakD  = '0;
            cntD   = '0;
        end else if (magVldQ) begin
            case (stateQ)
                IDLE: begin
                    stateD = ACCUM;
                    accD   = ACC_DW'(magQ);
                    peakD  = magQ;
                    cntD   = WINDOW_LOG2'(1);
                end
                ACCUM: begin
                    if (cntQ == LAST_CNT) begin
                        meanOutD  = DATA_DW'(accSum >> WINDOW_LOG2);
                        peakOutD  = magMax;
                        validOutD = 1'b1;
                        stateD    = IDLE;
                        accD      = '0;
                        peakD     = '0;
                        cntD      = '0;
                    end else begin
                        accD  = accSum;
                        peakD = magMax;
                        cntD  = cntQ + WINDOW_LOG2'(1);
                    end
                end
                default: begin
                    stateD = IDLE;
                    accD   = '0;
                    peakD  = '0;
                    cntD   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= IDLE;
            accQ      <= '0;
            peakQ     <= '0;
            cntQ      <= '0;
            meanOutQ  <= '0;
            peakOutQ  <= '0;
            validOutQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            accQ      <= accD;
            peakQ     <= peakD;
            cntQ      <= cntD;
            meanOutQ  <= meanOutD;
            peakOutQ  <= peakOutD;
            validOutQ <= validOutD;
        end
    end

    assign mean_o  = meanOutQ;
    assign peak_o  = peakOutQ;
    assign valid_o = validOutQ;
    assign busy_o  = (stateQ == ACCUM);

endmodule

// File: tb/tb_envelope_detector.sv
// Self-checking bench for envelope_detector: directed windows plus random
// traffic compared every cycle against a queue-based window model.
module tb_envelope_detector;

    localparam int DATA_DW     = 17;
    localparam int WINDOW_LOG2 = 8;
    localparam int N           = 1 << WINDOW_LOG2;

    logic               clk = 1'b0;
    logic               rst;
    logic [DATA_DW-1:0] data_i;
    logic               valid_i;
    logic               clear_i;
    logic [DATA_DW-1:0] mean_o;
    logic [DATA_DW-1:0] peak_o;
    logic               valid_o;
    logic               busy_o;

    int passCount  = 0;
    int checkCount = 0;

    // Reference model: magnitudes of the current window, plus the sample
    // still in flight one cycle behind the input.
    int window[$];
    bit inflightV;
    int inflightMag;
    int expMean;
    int expPeak;
    bit expValid;

    envelope_detector #(
        .DATA_DW    (DATA_DW),
        .WINDOW_LOG2(WINDOW_LOG2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .data_i (data_i),
        .valid_i(valid_i),
        .clear_i(clear_i),
        .mean_o (mean_o),
        .peak_o (peak_o),
        .valid_o(valid_o),
        .busy_o (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    task automatic modelReset();
        window.delete();
        inflightV   = 1'b0;
        inflightMag = 0;
        expMean     = 0;
        expPeak     = 0;
        expValid    = 1'b0;
    endtask

    task automatic modelStep(input bit v, input int value, input bit clr);
        longint sum;
        int     pk;
        expValid = 1'b0;
        if (clr) begin
            window.delete();
            inflightV = 1'b0;
        end else begin
            if (inflightV) begin
                window.push_back(inflightMag);
                if (window.size() == N) begin
                    sum = 0;
                    pk  = 0;
                    foreach (window[i]) begin
                        sum += window[i];
                        if (window[i] > pk) pk = window[i];
                    end
                    expMean  = int'(sum >>> WINDOW_LOG2);
                    expPeak  = pk;
                    expValid = 1'b1;
                    window.delete();
                end
            end
            inflightV   = v;
            inflightMag = (value < 0) ? -value : value;
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, " valid_o"}, longint'(valid_o), longint'(expValid));
        checkOutput({phase, " busy_o"},  longint'(busy_o),  longint'(window.size() != 0));
        checkOutput({phase, " mean_o"},  longint'(mean_o),  longint'(expMean));
        checkOutput({phase, " peak_o"},  longint'(peak_o),  longint'(expPeak));
    endtask

    task automatic applyStimulus(input string phase, input bit v, input int value, input bit clr);
        valid_i = v;
        data_i  = DATA_DW'(value);
        clear_i = clr;
        @(posedge clk);
        #1;
        modelStep(v, value, clr);
        checkAll(phase);
    endtask

    // Reset is raised between edges to exercise the asynchronous path.
    task automatic applyAsyncReset(input string phase);
        rst     = 1'b1;
        valid_i = 1'b0;
        clear_i = 1'b0;
        #2;
        modelReset();
        checkAll({phase, " in-reset"});
        @(posedge clk);
        #1;
        checkAll({phase, " in-reset-edge"});
        rst = 1'b0;
    endtask

    initial begin
        int pulses;
        rst     = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        clear_i = 1'b0;
        modelReset();
        #12;
        checkAll("reset");
        rst = 1'b0;

        $display("[TB] constant +100 window");
        for (int i = 0; i < N; i++) applyStimulus("const100", 1'b1, 100, 1'b0);
        applyStimulus("const100 tail", 1'b0, 0, 1'b0);
        checkOutput("const100 pulse", longint'(valid_o), 1);
        applyStimulus("const100 tail", 1'b0, 0, 1'b0);
        checkOutput("const100 mean", longint'(mean_o), 100);
        checkOutput("const100 peak", longint'(peak_o), 100);

        $display("[TB] alternating +/-1000, two windows");
        pulses = 0;
        for (int i = 0; i < 2 * N; i++) begin
            applyStimulus("alt1000", 1'b1, (i % 2 == 0) ? 1000 : -1000, 1'b0);
            if (valid_o) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("alt1000 tail", 1'b0, 0, 1'b0);
            if (valid_o) pulses++;
        end
        checkOutput("alt1000 pulses", longint'(pulses), 2);
        checkOutput("alt1000 mean", longint'(mean_o), 1000);

        $display("[TB] most-negative input");
        for (int i = 0; i < N - 1; i++) applyStimulus("minneg", 1'b1, -65536, 1'b0);
        applyStimulus("minneg last", 1'b1, 5, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("minneg tail", 1'b0, 0, 1'b0);
        checkOutput("minneg mean", longint'(mean_o), 65280);
        checkOutput("minneg peak", longint'(peak_o), 65536);

        $display("[TB] ramp with gaps");
        for (int i = 0; i < N; i++) begin
            applyStimulus("ramp", 1'b1, i, 1'b0);
            applyStimulus("ramp gap", 1'b0, 0, 1'b0);
            applyStimulus("ramp gap", 1'b0, 0, 1'b0);
        end
        checkOutput("ramp mean", longint'(mean_o), 127);
        checkOutput("ramp peak", longint'(peak_o), 255);

        $display("[TB] clear mid-window");
        for (int i = 0; i < 100; i++) applyStimulus("clr500", 1'b1, 500, 1'b0);
        applyStimulus("clr500 clear", 1'b1, 500, 1'b1);
        for (int i = 0; i < N; i++) applyStimulus("clr20", 1'b1, 20, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("clr20 tail", 1'b0, 0, 1'b0);
        checkOutput("clr20 mean", longint'(mean_o), 20);
        checkOutput("clr20 peak", longint'(peak_o), 20);

        $display("[TB] clear with last sample in flight");
        for (int i = 0; i < N; i++) applyStimulus("inflight", 1'b1, 9, 1'b0);
        applyStimulus("inflight clear", 1'b0, 0, 1'b1);
        checkOutput("inflight no pulse", longint'(valid_o), 0);
        for (int i = 0; i < N; i++) applyStimulus("after inflight", 1'b1, 3, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("after inflight tail", 1'b0, 0, 1'b0);
        checkOutput("after inflight mean", longint'(mean_o), 3);

        $display("[TB] reset mid-window");
        for (int i = 0; i < 200; i++) applyStimulus("rst300", 1'b1, 300, 1'b0);
        applyAsyncReset("rst300");
        for (int i = 0; i < N; i++) applyStimulus("rst7", 1'b1, 7, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus("rst7 tail", 1'b0, 0, 1'b0);
        checkOutput("rst7 mean", longint'(mean_o), 7);
        checkOutput("rst7 peak", longint'(peak_o), 7);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            bit v;
            bit clr;
            int value;
            v     = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 1499) == 0);
            value = int'($urandom_range(0, 131071)) - 65536;
            if ($urandom_range(0, 15) == 0) value = -65536;
            applyStimulus("random", v, value, clr);
        end
        for (int i = 0; i < 3; i++) applyStimulus("random tail", 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
